// File: rtl/aes_key_schedule_seq.sv
// Sequential AES key expansion (128/192/256) with one shared SubWord unit, one word per clock.
// Round keys are kept in an internal store, read by round index and streamed one word per write.
module aes_key_schedule_seq #(
    parameter bit AES256_EN = 1'b1,
    parameter bit RD_REG    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    output logic         err,
    output logic         w_valid,
    output logic [5:0]   w_idx,
    output logic [31:0]  w_data,
    input  logic [3:0]   rk_round,
    output logic [127:0] rk_out
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    state_t        state_q, state_d;
    logic [31:0]   store_q [0:63];
    logic [5:0]    i_q, i_d;
    logic [2:0]    j_q, j_d;
    logic [3:0]    nk_q, nk_d;
    logic [3:0]    nr_q, nr_d;
    logic [5:0]    t_q, t_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          key_valid_q, key_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          w_valid_q, w_valid_d;
    logic [5:0]    w_idx_q, w_idx_d;
    logic [31:0]   w_data_q, w_data_d;

    logic          key_ok;
    logic [3:0]    nk_new;
    logic          load_key;
    logic          wr_word;
    logic [31:0]   prev_w, back_w, sub_in, sub_w, temp_w, new_w;
    logic          is_rot, is_sub8;

    always_comb begin
        key_ok = (key_len != 2'd3) && ((key_len != 2'd2) || AES256_EN);
        case (key_len)
            2'd0:    nk_new = 4'd4;
            2'd1:    nk_new = 4'd6;
            default: nk_new = 4'd8;
        endcase
    end

    // j_q tracks i mod Nk, so Rcon/RotWord and the 256-bit SubWord-only step need no divider.
    always_comb begin
        prev_w  = store_q[i_q - 6'd1];
        back_w  = store_q[i_q - {2'b00, nk_q}];
        is_rot  = (j_q == 3'd0);
        is_sub8 = AES256_EN && (nk_q == 4'd8) && (j_q == 3'd4);
        sub_in  = is_rot ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_w   = subword(sub_in);
        if (is_rot) begin
            temp_w = sub_w ^ {rcon_q, 24'h000000};
        end else if (is_sub8) begin
            temp_w = sub_w;
        end else begin
            temp_w = prev_w;
        end
        new_w = back_w ^ temp_w;
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        nk_d        = nk_q;
        nr_d        = nr_q;
        t_d         = t_q;
        rcon_d      = rcon_q;
        key_valid_d = key_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        w_valid_d   = 1'b0;
        w_idx_d     = w_idx_q;
        w_data_d    = w_data_q;
        load_key    = 1'b0;
        wr_word     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!key_ok) begin
                        err_d = 1'b1;
                    end else begin
                        load_key    = 1'b1;
                        nk_d        = nk_new;
                        nr_d        = nk_new + 4'd6;
                        t_d         = {nk_new + 4'd7, 2'b00};
                        i_d         = {2'b00, nk_new};
                        j_d         = 3'd0;
                        rcon_d      = 8'h01;
                        key_valid_d = 1'b0;
                        state_d     = EXPAND;
                    end
                end
            end
            EXPAND: begin
                wr_word   = 1'b1;
                w_valid_d = 1'b1;
                w_idx_d   = i_q;
                w_data_d  = new_w;
                i_d       = i_q + 6'd1;
                if (is_rot) begin
                    rcon_d = xtime(rcon_q);
                end
                if ({1'b0, j_q} == nk_q - 4'd1) begin
                    j_d = 3'd0;
                end else begin
                    j_d = j_q + 3'd1;
                end
                if (i_q == t_q - 6'd1) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    key_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            nk_q        <= '0;
            nr_q        <= '0;
            t_q         <= '0;
            rcon_q      <= '0;
            key_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            w_valid_q   <= 1'b0;
            w_idx_q     <= '0;
            w_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            nk_q        <= nk_d;
            nr_q        <= nr_d;
            t_q         <= t_d;
            rcon_q      <= rcon_d;
            key_valid_q <= key_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            w_valid_q   <= w_valid_d;
            w_idx_q     <= w_idx_d;
            w_data_q    <= w_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 64; k++) begin
                store_q[k] <= '0;
            end
        end else if (load_key) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < nk_new) begin
                    store_q[k] <= key[255 - 32*k -: 32];
                end
            end
        end else if (wr_word) begin
            store_q[i_q] <= new_w;
        end
    end

    logic [127:0] rk_word;

    always_comb begin
        if (rk_round > nr_q) begin
            rk_word = '0;
        end else begin
            rk_word = {store_q[{rk_round, 2'd0}], store_q[{rk_round, 2'd1}],
                       store_q[{rk_round, 2'd2}], store_q[{rk_round, 2'd3}]};
        end
    end

    generate
        if (RD_REG) begin : g_rd_reg
            logic [127:0] rk_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rk_q <= '0;
                end else begin
                    rk_q <= rk_word;
                end
            end
            assign rk_out = rk_q;
        end else begin : g_rd_comb
            assign rk_out = rk_word;
        end
    endgenerate

    assign busy      = (state_q == EXPAND);
    assign done      = done_q;
    assign key_valid = key_valid_q;
    assign err       = err_q;
    assign w_valid   = w_valid_q;
    assign w_idx     = w_idx_q;
    assign w_data    = w_data_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Bench for aes_key_schedule_seq: known-answer vectors plus random keys against a
// FIPS-197 style reference model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_schedule_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start2;
    logic [1:0]   key_len, key_len2;
    logic [255:0] key, key2;
    logic         busy, done, key_valid, err, w_valid;
    logic         busy2, done2, key_valid2, err2, w_valid2;
    logic [5:0]   w_idx, w_idx2;
    logic [31:0]  w_data, w_data2;
    logic [3:0]   rk_round, rk_round2;
    logic [127:0] rk_out, rk_out2;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sb [0:255];
    logic [7:0]   rcon_tab [0:9];
    logic [31:0]  mw [0:63];
    logic [31:0]  gw [0:63];
    logic [127:0] rkg [0:15];

    always #5 clk = ~clk;

    aes_key_schedule_seq dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
        .busy(busy), .done(done), .key_valid(key_valid), .err(err),
        .w_valid(w_valid), .w_idx(w_idx), .w_data(w_data),
        .rk_round(rk_round), .rk_out(rk_out)
    );

    aes_key_schedule_seq #(.AES256_EN(1'b0), .RD_REG(1'b0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .key_len(key_len2), .key(key2),
        .busy(busy2), .done(done2), .key_valid(key_valid2), .err(err2),
        .w_valid(w_valid2), .w_idx(w_idx2), .w_data(w_data2),
        .rk_round(rk_round2), .rk_out(rk_out2)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int c = 1; c < 256; c++) begin
            if (a != 8'h00 && gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
        end
        s = 8'h63;
        for (int r = 0; r < 5; r++) begin
            s = s ^ 8'((inv << r) | (inv >> (8 - r)));
        end
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic model(input logic [255:0] k, input int nk);
        logic [31:0] tmp;
        int t = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < t; i++) begin
            tmp = mw[i-1];
            if (i % nk == 0)
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                tmp = subw(tmp);
            mw[i] = mw[i-nk] ^ tmp;
        end
    endtask

    task automatic run_exp(input logic [255:0] k, input logic [1:0] kl, input bit poke);
        int nk, nr, t, n, nxt;
        bit fin;
        nk = 4 + 2 * int'(kl);
        nr = nk + 6;
        t  = 4 * (nr + 1);
        model(k, nk);
        @(negedge clk);
        key = k; key_len = kl; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("kv_cleared", key_valid, 1'b0);
        nxt = nk; fin = 1'b0; n = 0;
        while (!fin && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (poke && n == 10) begin
                start = 1'b1; key = ~k; key_len = 2'd3;
            end else begin
                start = 1'b0;
            end
            if (w_valid) begin
                chk("w_idx", w_idx, nxt);
                chk("w_data", w_data, mw[nxt]);
                gw[w_idx] = w_data;
                nxt++;
            end
            if (done) fin = 1'b1;
        end
        start = 1'b0;
        chk("done_latency", n, t - nk);
        chk("strobe_count", nxt, t);
        chk("busy_at_done", busy, 1'b0);
        chk("kv_at_done", key_valid, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("w_valid_off", w_valid, 1'b0);
        chk("err_quiet", err, 1'b0);
        for (int r = 0; r < 16; r++) begin
            rk_round = 4'(r);
            @(posedge clk);
            @(negedge clk);
            rkg[r] = rk_out;
            chk("rk_out", rk_out, (r > nr) ? 128'h0 : {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rk;
        int n;
        for (int a = 0; a < 256; a++) sb[a] = sbox_m(8'(a));
        rcon_tab[0] = 8'h01; rcon_tab[1] = 8'h02; rcon_tab[2] = 8'h04; rcon_tab[3] = 8'h08;
        rcon_tab[4] = 8'h10; rcon_tab[5] = 8'h20; rcon_tab[6] = 8'h40; rcon_tab[7] = 8'h80;
        rcon_tab[8] = 8'h1b; rcon_tab[9] = 8'h36;

        rst = 1'b1; start = 1'b0; key_len = 2'd0; key = '0; rk_round = 4'd0;
        start2 = 1'b0; key_len2 = 2'd0; key2 = '0; rk_round2 = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {busy, done, key_valid, err, w_valid, w_idx, w_data}, '0);
        chk("rst_rk", rk_out, '0);
        rst = 1'b0;

        run_exp({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'd0, 1'b0);
        chk("kat128_w4", gw[4], 32'ha0fafe17);
        chk("kat128_r10", rkg[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_exp({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 2'd1, 1'b1);
        chk("kat192_w6", gw[6], 32'hfe0c91f7);
        chk("kat192_r12", rkg[12], 128'he98ba06f448c773c8ecc720401002202);
        chk("kat192_r13", rkg[13], 128'h0);

        run_exp(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 2'd2, 1'b0);
        chk("kat256_w12", gw[12], 32'ha8b09c1a);
        chk("kat256_r14", rkg[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Rejected starts on both instances.
        @(negedge clk);
        key_len = 2'd3; start = 1'b1; key_len2 = 2'd2; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; start2 = 1'b0;
        chk("err_len3", err, 1'b1);
        chk("busy_len3", busy, 1'b0);
        chk("err2_len2", err2, 1'b1);
        chk("busy2_len2", busy2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("err_one_cycle", err, 1'b0);
        chk("err2_one_cycle", err2, 1'b0);
        chk("kv_kept_on_err", key_valid, 1'b1);

        // Combinational read port on the second instance.
        model({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        key2 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}; key_len2 = 2'd0; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("dut2_latency", n, 40);
        rk_round2 = 4'd10;
        #1;
        chk("dut2_rk10_comb", rk_out2, {mw[40], mw[41], mw[42], mw[43]});
        rk_round2 = 4'd3;
        #1;
        chk("dut2_rk3_comb", rk_out2, {mw[12], mw[13], mw[14], mw[15]});

        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 8; w++) rk[32*w +: 32] = $urandom;
            run_exp(rk, 2'($urandom_range(0, 2)), it[0]);
        end

        // Reset in the middle of an AES-128 run, then reset racing a start.
        @(negedge clk);
        key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}; key_len = 2'd0; start = 1'b1;
        rk_round = 4'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_run", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_outs", {busy, done, key_valid, err, w_valid, w_idx, w_data}, '0);
        chk("midrst_rk", rk_out, '0);
        @(posedge clk);
        @(negedge clk);
        chk("store_cleared", rk_out, '0);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_beats_start", busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("still_idle", busy, 1'b0);

        run_exp({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'd0, 1'b0);
        chk("restart_r10", rkg[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
